// File: rtl/chan_sel_pkg.sv
// ============================================================================
// Module      : chan_sel_pkg
// Description : Shared mode encodings and select-width helper for chan_sel_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chan_sel_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single-channel build still needs a 1-bit select, so clamp at 1.
    function automatic int calc_sel_w(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin finder: first valid index at or after ptr, with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import chan_sel_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = calc_sel_w(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SEL_W-1:0]    ptr,
    output logic                found,
    output logic [SEL_W-1:0]    idx
);

    logic [SEL_W-1:0] w_pos;

    // Scan from the farthest offset down so the nearest valid channel wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_pos = SEL_W'((int'(ptr) + k) % CHANNELS);
            if (valid[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/chan_sel_reg.sv
// ============================================================================
// Module      : chan_sel_reg
// Description : Registered N-channel selector (fixed or round-robin) with valid/ready and transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_sel_reg
    import chan_sel_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = calc_sel_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          xfer_cnt
);

    localparam int               PAD_CH      = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] C_LAST_CHAN = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_xfer_cnt;

    logic                w_load;
    logic [PAD_CH-1:0]   w_valid_pad;
    logic                w_rr_found;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_grant;
    logic [SEL_W-1:0]    w_gidx;
    logic [SEL_W-1:0]    w_ptr_next;
    logic [WIDTH-1:0]    w_words [CHANNELS];

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_words
            assign w_words[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .valid (in_valid),
        .ptr   (r_ptr),
        .found (w_rr_found),
        .idx   (w_rr_idx)
    );

    assign w_load = !r_out_valid || out_ready;

    // Select indices beyond CHANNELS land on zero-padded flags and never grant.
    assign w_valid_pad = PAD_CH'(in_valid);

    always_comb begin
        w_grant = 1'b0;
        w_gidx  = '0;
        if (mode == MODE_RR) begin
            w_gidx  = w_rr_idx;
            w_grant = rst_n && w_load && w_rr_found;
        end else begin
            w_gidx  = sel;
            w_grant = rst_n && w_load && w_valid_pad[sel];
        end
    end

    assign in_ready   = w_grant ? (CHANNELS'(1) << w_gidx) : '0;
    assign w_ptr_next = (w_gidx == C_LAST_CHAN) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            if (w_grant) begin
                r_out_data  <= w_words[w_gidx];
                r_out_chan  <= w_gidx;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_grant && (mode == MODE_RR)) begin
                r_ptr <= w_ptr_next;
            end
            if (r_out_valid && out_ready) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

`default_nettype wire
